// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Shares the single RAM port (MFA/MFC handshake) between the instruction
// fetch requester and the data (load/store/trap-vector) requester. Only one
// transaction is in flight at a time. The winning request's fields are
// latched and drive the RAM strobes until the transaction completes. A
// saturating 8-bit watchdog aborts a RAM access that never signals MFC.
//
// Parameters
//   TIMEOUT      WAIT cycles tolerated without ramMFC before abort (2..255)
//
// Ports
//   Clk, reset             rising-edge clock, asynchronous active-high reset
//   fReq/fRW/fSize/fAddr   fetch request, held until fDone
//   dReq/dRW/dSize/dAddr   data request, held until dDone
//   dWData                 store data (fetch has none, drives zero)
//   fGrant/dGrant          owner indication, ISSUE through DONE
//   fDone/dDone            one-cycle completion pulse to the owner
//   rData                  read data, valid with done, held afterwards
//   err                    high with done when the access timed out
//   ramMFA/ramRW/ramDataSize/ramAddress/ramDataOut   registered RAM strobes
//   ramDataIn, ramMFC      RAM read data and completion handshake
//
// Configuration
//   RAM_ARB_RR_EN defined   : round-robin between the two requesters on a
//                             simultaneous request.
//   RAM_ARB_RR_EN undefined : fixed priority, data beats fetch.

module ram_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        fReq,
  input  logic        fRW,
  input  logic [1:0]  fSize,
  input  logic [8:0]  fAddr,
  input  logic        dReq,
  input  logic        dRW,
  input  logic [1:0]  dSize,
  input  logic [8:0]  dAddr,
  input  logic [31:0] dWData,
  output logic        fGrant,
  output logic        dGrant,
  output logic        fDone,
  output logic        dDone,
  output logic [31:0] rData,
  output logic        err,
  output logic        ramMFA,
  output logic        ramRW,
  output logic [1:0]  ramDataSize,
  output logic [8:0]  ramAddress,
  output logic [31:0] ramDataOut,
  input  logic [31:0] ramDataIn,
  input  logic        ramMFC
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_RECOVER
  } state_t;

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  state_t     state;
  logic       owner_d;   // 1: data requester owns the port, 0: fetch
  logic [7:0] wdog;
  logic       pick_d;    // arbitration result for the current IDLE cycle

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef RAM_ARB_RR_EN
  logic last_d;          // 1: data won the previous arbitration

  // On a tie the port that did not win last time goes next.
  always_comb pick_d = dReq & (~fReq | ~last_d);
`else
  always_comb pick_d = dReq;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      wdog        <= '0;
      fGrant      <= 1'b0;
      dGrant      <= 1'b0;
      fDone       <= 1'b0;
      dDone       <= 1'b0;
      rData       <= '0;
      err         <= 1'b0;
      ramMFA      <= 1'b0;
      ramRW       <= 1'b0;
      ramDataSize <= '0;
      ramAddress  <= '0;
      ramDataOut  <= '0;
`ifdef RAM_ARB_RR_EN
      last_d      <= 1'b0;
`endif
    end else begin
      case (state)
        // Arbitrate and latch the winner's request fields.
        S_IDLE: begin
          if (fReq | dReq) begin
            owner_d     <= pick_d;
            fGrant      <= ~pick_d;
            dGrant      <= pick_d;
            ramMFA      <= 1'b1;
            ramRW       <= pick_d ? dRW   : fRW;
            ramDataSize <= pick_d ? dSize : fSize;
            ramAddress  <= pick_d ? dAddr : fAddr;
            ramDataOut  <= pick_d ? dWData : 32'd0;
`ifdef RAM_ARB_RR_EN
            last_d      <= pick_d;
`endif
            state       <= S_ISSUE;
          end
        end

        // Strobe is on; any MFC still high from elsewhere is not sampled here.
        S_ISSUE: begin
          wdog  <= '0;
          state <= S_WAIT;
        end

        // MFC completes the access; otherwise the watchdog eventually aborts.
        S_WAIT: begin
          if (ramMFC) begin
            if (!ramRW) rData <= ramDataIn;
            err    <= 1'b0;
            fDone  <= ~owner_d;
            dDone  <= owner_d;
            ramMFA <= 1'b0;
            state  <= S_DONE;
          end else if (wdog == TIMEOUT_L) begin
            rData  <= '0;
            err    <= 1'b1;
            fDone  <= ~owner_d;
            dDone  <= owner_d;
            ramMFA <= 1'b0;
            state  <= S_DONE;
          end else begin
            wdog <= sat_inc8(wdog);
          end
        end

        // Done pulse lasts exactly this cycle; ownership ends with it.
        S_DONE: begin
          fDone  <= 1'b0;
          dDone  <= 1'b0;
          fGrant <= 1'b0;
          dGrant <= 1'b0;
          err    <= 1'b0;
          state  <= S_RECOVER;
        end

        // The RAM must drop MFC before the next access can start.
        S_RECOVER: begin
          if (!ramMFC) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
  localparam int TIMEOUT = 8;

  logic        Clk = 1'b0;
  logic        reset;
  logic        fReq, fRW, dReq, dRW;
  logic [1:0]  fSize, dSize;
  logic [8:0]  fAddr, dAddr;
  logic [31:0] dWData;
  logic        fGrant, dGrant, fDone, dDone, err;
  logic [31:0] rData;
  logic        ramMFA, ramRW;
  logic [1:0]  ramDataSize;
  logic [8:0]  ramAddress;
  logic [31:0] ramDataOut;
  logic [31:0] ramDataIn;
  logic        ramMFC;

  ram_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .reset(reset),
    .fReq(fReq), .fRW(fRW), .fSize(fSize), .fAddr(fAddr),
    .dReq(dReq), .dRW(dRW), .dSize(dSize), .dAddr(dAddr), .dWData(dWData),
    .fGrant(fGrant), .dGrant(dGrant), .fDone(fDone), .dDone(dDone),
    .rData(rData), .err(err),
    .ramMFA(ramMFA), .ramRW(ramRW), .ramDataSize(ramDataSize),
    .ramAddress(ramAddress), .ramDataOut(ramDataOut),
    .ramDataIn(ramDataIn), .ramMFC(ramMFC)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int g_data = 0;

  // Reference model state: who won last, and what rData should hold.
  logic        m_last_d;
  logic [31:0] m_rdata;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_d = 1'b0;
    m_rdata  = 32'd0;
  endtask

  // One complete transaction, with the bench acting as the RAM.
  // d: WAIT cycle index in which MFC is raised; no_mfc: RAM never answers.
  // hold: extra RECOVER cycles with MFC still high.
  task automatic run_txn(input logic fr, input logic dr, input logic drw,
                         input logic [1:0] fs, input logic [1:0] ds,
                         input logic [8:0] fa, input logic [8:0] da,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int d, input bit no_mfc, input int hold,
                         input bit early_mfc, input bit drop_req, input string tag);
    logic        win_d;
    logic        exp_rw;
    logic [1:0]  exp_sz;
    logic [8:0]  exp_a;
    logic [31:0] exp_wd;
    int          exp_i;
    bit          exp_err;

    fReq = fr; dReq = dr; fRW = 1'b0; dRW = drw;
    fSize = fs; dSize = ds; fAddr = fa; dAddr = da; dWData = wd;
    ramMFC = 1'b0;

    if (fr && dr) begin
`ifdef RAM_ARB_RR_EN
      win_d = ~m_last_d;
`else
      win_d = 1'b1;
`endif
    end else begin
      win_d = dr;
    end
    m_last_d = win_d;
    exp_rw  = win_d ? drw : 1'b0;
    exp_sz  = win_d ? ds : fs;
    exp_a   = win_d ? da : fa;
    exp_wd  = win_d ? wd : 32'd0;
    exp_err = no_mfc || (d > TIMEOUT);
    exp_i   = exp_err ? TIMEOUT : d;

    step();  // ISSUE
    if (dGrant) g_data++;
    tests++; if (dGrant !== win_d || fGrant !== ~win_d) begin fails++; $display("FAIL %s issue_grant: got f=%b d=%b want d=%b", tag, fGrant, dGrant, win_d); end
    tests++; if (ramMFA !== 1'b1) begin fails++; $display("FAIL %s issue_mfa: got %b want 1", tag, ramMFA); end
    tests++; if ({ramRW, ramDataSize, ramAddress, ramDataOut} !== {exp_rw, exp_sz, exp_a, exp_wd}) begin fails++; $display("FAIL %s issue_fields: got rw=%b sz=%b a=%h wd=%h want rw=%b sz=%b a=%h wd=%h", tag, ramRW, ramDataSize, ramAddress, ramDataOut, exp_rw, exp_sz, exp_a, exp_wd); end

    // Requester inputs change freely once the transaction is latched.
    fAddr = 9'($urandom); dAddr = 9'($urandom); dWData = $urandom;
    fSize = 2'($urandom); dSize = 2'($urandom); dRW = 1'($urandom);
    if (drop_req) begin fReq = 1'b0; dReq = 1'b0; end
    if (early_mfc) begin ramMFC = 1'b1; ramDataIn = ~rd; end

    step();  // first WAIT cycle
    ramMFC = 1'b0;
    for (int i = 0; i <= TIMEOUT + 1; i++) begin
      tests++; if (ramMFA !== 1'b1 || fDone !== 1'b0 || dDone !== 1'b0) begin fails++; $display("FAIL %s wait_%0d: got mfa=%b fdone=%b ddone=%b want mfa=1 done=0", tag, i, ramMFA, fDone, dDone); end
      tests++; if ({dGrant, ramRW, ramDataSize, ramAddress, ramDataOut} !== {win_d, exp_rw, exp_sz, exp_a, exp_wd}) begin fails++; $display("FAIL %s wait_fields_%0d: got g=%b rw=%b a=%h wd=%h want g=%b rw=%b a=%h wd=%h", tag, i, dGrant, ramRW, ramAddress, ramDataOut, win_d, exp_rw, exp_a, exp_wd); end
      if (!no_mfc && i == d) begin ramMFC = 1'b1; ramDataIn = rd; end
      step();
      if (i == exp_i) break;
    end

    // DONE cycle
    m_rdata = exp_err ? 32'd0 : (exp_rw ? m_rdata : rd);
    tests++; if (fDone !== ~win_d || dDone !== win_d) begin fails++; $display("FAIL %s done_pulse: got f=%b d=%b want d=%b", tag, fDone, dDone, win_d); end
    tests++; if (err !== exp_err) begin fails++; $display("FAIL %s err: got %b want %b", tag, err, exp_err); end
    tests++; if (rData !== m_rdata) begin fails++; $display("FAIL %s rdata: got %h want %h", tag, rData, m_rdata); end
    tests++; if (ramMFA !== 1'b0 || dGrant !== win_d || fGrant !== ~win_d) begin fails++; $display("FAIL %s done_state: got mfa=%b f=%b d=%b want mfa=0 d=%b", tag, ramMFA, fGrant, dGrant, win_d); end

    ramDataIn = $urandom;
    if (hold == 0) ramMFC = 1'b0;
    step();  // RECOVER
    for (int h = 0; h < hold; h++) begin
      tests++; if ({fGrant, dGrant, fDone, dDone, ramMFA} !== 5'b0) begin fails++; $display("FAIL %s recover_hold_%0d: got g=%b%b done=%b%b mfa=%b want all 0", tag, h, fGrant, dGrant, fDone, dDone, ramMFA); end
      step();
    end
    ramMFC = 1'b0;
    tests++; if ({fGrant, dGrant, fDone, dDone, ramMFA} !== 5'b0) begin fails++; $display("FAIL %s recover: got g=%b%b done=%b%b mfa=%b want all 0", tag, fGrant, dGrant, fDone, dDone, ramMFA); end
    step();  // IDLE
    tests++; if ({fGrant, dGrant, fDone, dDone, ramMFA} !== 5'b0) begin fails++; $display("FAIL %s idle: got g=%b%b done=%b%b mfa=%b want all 0", tag, fGrant, dGrant, fDone, dDone, ramMFA); end
    tests++; if (rData !== m_rdata) begin fails++; $display("FAIL %s rdata_held: got %h want %h", tag, rData, m_rdata); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fReq = 1'b1; dReq = 1'b1; fRW = 1'b0; dRW = 1'b1;
    fSize = 2'b11; dSize = 2'b11; fAddr = 9'h1FF; dAddr = 9'h1FF;
    dWData = 32'hFFFF_FFFF; ramDataIn = 32'hFFFF_FFFF; ramMFC = 1'b1;
    step(); step();
    tests++; if ({fGrant, dGrant, fDone, dDone, err, ramMFA, ramRW} !== 7'b0) begin fails++; $display("FAIL reset_ctrl: got g=%b%b done=%b%b err=%b mfa=%b rw=%b want all 0", fGrant, dGrant, fDone, dDone, err, ramMFA, ramRW); end
    tests++; if ({ramDataSize, ramAddress} !== 11'b0) begin fails++; $display("FAIL reset_addr: got sz=%b a=%h want 0", ramDataSize, ramAddress); end
    tests++; if (ramDataOut !== 32'd0 || rData !== 32'd0) begin fails++; $display("FAIL reset_data: got out=%h rdata=%h want 0", ramDataOut, rData); end
    fReq = 1'b0; dReq = 1'b0; ramMFC = 1'b0;
    reset = 1'b0;
    model_reset();
    step();
  endtask

  task automatic test_no_request();
    for (int i = 0; i < 3; i++) begin
      // A request that rises and falls between edges is never seen.
      #2 fReq = 1'b1; dReq = 1'b1;
      #2 fReq = 1'b0; dReq = 1'b0;
      step();
      tests++; if ({fGrant, dGrant, ramMFA} !== 3'b0) begin fails++; $display("FAIL no_req_%0d: got g=%b%b mfa=%b want 0", i, fGrant, dGrant, ramMFA); end
    end
  endtask

  task automatic test_fetch_read();
    run_txn(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 9'h010, 9'h000, 32'd0,
            32'h8C22_0004, 2, 1'b0, 0, 1'b0, 1'b0, "fetch_read");
    fReq = 1'b0;
  endtask

  task automatic test_data_write();
    run_txn(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, 9'h000, 9'h1C0, 32'hDEAD_BEEF,
            32'h1234_5678, 1, 1'b0, 0, 1'b0, 1'b0, "data_write");
    dReq = 1'b0;
  endtask

  task automatic test_simultaneous();
    int exp_data;
`ifdef RAM_ARB_RR_EN
    exp_data = 2;
`else
    exp_data = 4;
`endif
    g_data = 0;
    for (int t = 0; t < 4; t++)
      run_txn(1'b1, 1'b1, 1'b0, 2'b11, 2'b10, 9'h040 + 9'(t), 9'h100 + 9'(t), 32'd0,
              $urandom, 0, 1'b0, 0, 1'b0, 1'b0, "simultaneous");
    tests++; if (g_data !== exp_data) begin fails++; $display("FAIL simultaneous_count: got %0d data grants want %0d", g_data, exp_data); end
    fReq = 1'b0; dReq = 1'b0;
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 9'h0A4, 9'h000, 32'd0,
            32'h5555_AAAA, 0, 1'b1, 0, 1'b1, 1'b0, "timeout");
    run_txn(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 9'h0A8, 9'h000, 32'd0,
            32'hCAFE_F00D, 3, 1'b0, 0, 1'b1, 1'b0, "after_timeout");
    fReq = 1'b0;
  endtask

  task automatic test_reset_mid();
    fReq = 1'b1; fRW = 1'b0; fSize = 2'b11; fAddr = 9'h0C0; ramMFC = 1'b0;
    step(); step(); step();   // ISSUE, WAIT, WAIT
    #2 reset = 1'b1;
    #1;
    tests++; if ({ramMFA, fGrant, fDone} !== 3'b0) begin fails++; $display("FAIL reset_mid: got mfa=%b grant=%b done=%b want 0", ramMFA, fGrant, fDone); end
    fReq = 1'b0; ramMFC = 1'b1; ramDataIn = 32'h0BAD_0BAD;
    step();
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if ({fDone, dDone, fGrant, ramMFA} !== 4'b0) begin fails++; $display("FAIL reset_mid_nodone_%0d: got done=%b%b g=%b mfa=%b want 0", i, fDone, dDone, fGrant, ramMFA); end
    end
    ramMFC = 1'b0;
    run_txn(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 9'h0C4, 9'h000, 32'd0,
            32'h2400_0001, 1, 1'b0, 0, 1'b0, 1'b0, "after_reset");
    fReq = 1'b0;
  endtask

  task automatic test_recover_hold();
    // Fetch stays requesting through the whole hold window.
    run_txn(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 9'h020, 9'h000, 32'd0,
            32'h0000_1111, 0, 1'b0, 3, 1'b0, 1'b0, "recover_hold");
    fReq = 1'b0;
  endtask

  task automatic test_drop_after_grant();
    run_txn(1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 9'h000, 9'h0F2, 32'h0,
            32'h7777_0000, 2, 1'b0, 0, 1'b0, 1'b1, "drop_after_grant");
  endtask

  task automatic test_random();
    logic [1:0] r;
    bit nm;
    for (int t = 0; t < 20; t++) begin
      r = 2'($urandom_range(1, 3));
      nm = ($urandom_range(0, 5) == 0);
      run_txn(r[0], r[1], 1'($urandom), 2'($urandom), 2'($urandom),
              9'($urandom), 9'($urandom), $urandom, $urandom,
              $urandom_range(0, 4), nm, $urandom_range(0, 2),
              1'($urandom), 1'($urandom), "random");
      fReq = 1'b0; dReq = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_no_request();
    test_fetch_read();
    test_data_write();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_recover_hold();
    test_drop_after_grant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, %0d tests run", tests);
    $fatal(1);
  end

endmodule
